// File: rtl/ct_mask_expander.sv
// Expands a packed run of compressed-table values into a dense lane vector.
// One read per set mask bit; each returned value fills the lowest still-pending lane.
module ct_mask_expander #(
  parameter int MASK_W = 20,
  parameter int CT_AW  = 11,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     CT_read,
  input  logic [CT_AW-1:0]         CT_address,
  input  logic [MASK_W-1:0]        Mask,
  output logic                     in_ready,
  output logic                     mem_rd_en,
  output logic [CT_AW-1:0]         mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MASK_W*DATA_W-1:0] out_data,
  output logic [MASK_W-1:0]        out_mask
);

  localparam int CW = $clog2(MASK_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                     r_state;
  logic [MASK_W-1:0]          r_wm;
  logic [CW-1:0]              r_cnt;
  logic                       r_rd_en;
  logic                       r_rd_d;
  logic [CT_AW-1:0]           r_addr;
  logic                       r_out_valid;
  logic [MASK_W*DATA_W-1:0]   r_out_data;
  logic [MASK_W-1:0]          r_out_mask;

  logic [CW-1:0]              w_pop;
  logic [MASK_W-1:0]          w_low;
  logic                       w_cap;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < MASK_W; i++) begin
      w_pop = w_pop + CW'(Mask[i]);
    end
  end

  // Priority encoder in one-hot form: isolates the lowest pending lane.
  assign w_low = r_wm & (~r_wm + MASK_W'(1));
  assign w_cap = r_rd_d && (r_state == S_FETCH || r_state == S_DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wm        <= '0;
      r_cnt       <= '0;
      r_rd_en     <= 1'b0;
      r_rd_d      <= 1'b0;
      r_addr      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
    end else begin
      r_rd_d <= r_rd_en;
      if (w_cap) begin
        for (int i = 0; i < MASK_W; i++) begin
          if (w_low[i]) r_out_data[i*DATA_W +: DATA_W] <= mem_rdata;
        end
        r_wm <= r_wm & ~w_low;
      end
      case (r_state)
        S_IDLE: begin
          if (in_valid && CT_read) begin
            r_wm       <= Mask;
            r_out_mask <= Mask;
            r_out_data <= '0;
            r_cnt      <= w_pop;
            if (w_pop != '0) begin
              r_rd_en <= 1'b1;
              r_addr  <= CT_address;
              r_state <= S_FETCH;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_addr <= r_addr + CT_AW'(1);
          end
        end
        S_DRAIN: begin
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          // Entered straight from IDLE for an empty mask, so valid rises here.
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign mem_rd_en = r_rd_en;
  assign mem_addr  = r_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_mask  = r_out_mask;

endmodule

// File: doc/ct_mask_expander.md
Name: ct_mask_expander

Overview:
- Downstream stage of the address translation table.
- Takes a compressed-table base address (CT_address) and a 20-bit lane mask.
- Fetches one packed nonzero value per set mask bit from the compressed-table memory, at consecutive addresses starting at the base.
- Scatters the fetched values into a 20-lane dense vector; lanes whose mask bit is 0 are zero.

Parameters:
- MASK_W, 20, number of lanes; width of Mask.
- CT_AW, 11, compressed-table address width.
- DATA_W, 8, width of one packed value.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- in_valid  input  1  upstream request qualifier
- CT_read  input  1  upstream read-enable; a request is accepted only when it is 1
- CT_address  input  CT_AW  base address of the packed values
- Mask  input  MASK_W  lane mask; bit i = 1 means lane i is nonzero
- in_ready  output  1  high only in IDLE
- mem_rd_en  output  1  compressed-table read strobe
- mem_addr  output  CT_AW  compressed-table read address
- mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_rd_en
- out_valid  output  1  expanded vector valid
- out_ready  input  1  downstream accept
- out_data  output  MASK_W*DATA_W  lane i = bits [i*DATA_W +: DATA_W]
- out_mask  output  MASK_W  copy of the accepted Mask

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, in_ready = 1, mem_rd_en = 0, mem_addr = 0, out_valid = 0, out_data = 0, out_mask = 0.
  - Counters are cleared; a read in flight is discarded.
- Accept: at a rising edge with state IDLE, in_valid = 1 and CT_read = 1:
  - latch base = CT_address and the working mask wm = Mask;
  - out_mask <= Mask; out_data <= 0;
  - issue count n <= popcount(Mask).
- In IDLE, in_valid = 1 with CT_read = 0 is ignored.
- IDLE -> FETCH on accept when n > 0. IDLE -> DONE on accept when Mask = 0; out_valid then rises on the edge after accept, with out_data = 0.
- FETCH:
  - mem_rd_en = 1 for exactly n consecutive cycles; the k-th read (k = 0..n-1) has mem_addr = (base + k) mod 2^CT_AW (wraps at 0x7FF -> 0x000).
  - Each returned mem_rdata is written to lane j = index of the lowest set bit of wm, and that bit of wm is cleared.
  - Packed values therefore fill lanes in ascending lane order.
- After the last read is issued, the FSM goes FETCH -> DRAIN for one cycle to capture the final data. DRAIN -> DONE.
- Latency: with accept at edge E0, reads are issued in the cycles between edges E0..E(n); the last data is captured at E(n+1); out_valid = 1 from E(n+1) onward. Total latency is n+1 edges.
- DONE:
  - out_valid = 1; out_data and out_mask are held stable until out_valid && out_ready.
  - On that edge: out_valid <= 0, state <= IDLE.
  - out_data and out_mask keep their values until the next accept.
- in_ready = (state == IDLE). No new request is accepted during FETCH, DRAIN or DONE, so there is no overlap.
- mem_rd_en is never 1 outside FETCH. mem_addr holds its last value when idle.
- Arithmetic:
  - popcount result is 5 bits (0..20).
  - Address add is CT_AW bits, unsigned, and wraps.
  - Lane index comes from a priority encoder on wm (lowest first).
- Reset asserted mid-FETCH or mid-DONE: everything returns to reset values immediately. Data returning after reset deasserts is ignored.

Test Plan:
- Mask = 0x00000, CT_address = 0x010 -> no mem_rd_en; out_valid 1 edge after accept; out_data = 0, out_mask = 0.
- Mask = 0x00001, CT_address = 0x005, mem[5] = 0xA5 -> one read at addr 0x005; lane 0 = 0xA5, lanes 1..19 = 0; out_valid 2 edges after accept.
- Mask = 0x80003, CT_address = 0x100, mem[0x100..0x102] = 0x11, 0x22, 0x33 -> reads at 0x100, 0x101, 0x102 on consecutive cycles; lane0 = 0x11, lane1 = 0x22, lane19 = 0x33, others 0.
- Mask = 0xFFFFF, CT_address = 0x7FA -> 20 reads at 0x7FA..0x7FF, then 0x000..0x00D; lane i = mem[(0x7FA+i) mod 2048]; out_valid 21 edges after accept.
- out_ready held 0 for 5 cycles in DONE, with in_valid = 1 and a new request presented -> out_data stable, in_ready = 0, no reads; then out_ready = 1 -> IDLE, and the next request is accepted on the following edge.
- rst pulsed low during the 3rd read of Mask = 0x000FF -> mem_rd_en and out_valid drop to 0 immediately; after release, Mask = 0x00002 at base 0x020 yields lane1 = mem[0x020] only. Also: CT_read = 0 with in_valid = 1 -> no accept.
